pipe_ctrl: RTL

Pipeline control unit for the five-stage core. It merges stall requests from ID, EX and MEM into the shared `stall[5:0]` vector that drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It issues a one-cycle pipeline flush with a redirect PC when MEM reports an exception or ERET, then masks further requests for a fixed hold-off window. It also counts stall cycles for performance monitoring and flags runaway stalls with a watchdog.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus between the core stages and pipe_ctrl.
// The master side is the pipeline. It raises requests and exceptions and receives stall/flush/redirect.
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: stall merge, exception flush/redirect with post-flush hold-off,
// stall-cycle performance counter and a sticky runaway-stall watchdog.
module pipe_ctrl #(
  parameter int unsigned HOLDOFF_CYC = 2,
  parameter int unsigned STALL_LIMIT = 255,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam int unsigned HCNT_W    = 4;
  localparam int unsigned WCNT_W    = 16;
  localparam int unsigned CYC_W     = 32;
  localparam int unsigned STALL_W   = 6;
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

  localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLDOFF_CYC - 1);
  localparam logic [WCNT_W-1:0] WCNT_TRIP = WCNT_W'(STALL_LIMIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [HCNT_W-1:0]   hcnt;
  logic [WCNT_W-1:0]   wcnt;
  logic [CYC_W-1:0]    stall_cycles_q;
  logic                stall_timeout_q;

  logic                exc_take_c;
  logic [STALL_W-1:0]  stall_c;
  logic                flush_c;
  logic [31:0]         new_pc_c;

  // Combinational stall/flush/redirect; an exception in IDLE outranks every stall request.
  always_comb begin
    exc_take_c = 1'b0;
    stall_c    = STALL_NONE;
    flush_c    = 1'b0;
    new_pc_c   = 32'h0;
    if (state == IDLE) begin
      if (bus.excepttype_i != 32'h0) begin
        exc_take_c = 1'b1;
        flush_c    = 1'b1;
        new_pc_c   = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (bus.stallreq_from_mem) begin
        stall_c = STALL_MEM;
      end else if (bus.stallreq_from_ex) begin
        stall_c = STALL_EX;
      end else if (bus.stallreq_from_id) begin
        stall_c = STALL_ID;
      end
    end
  end

  // Flush/hold-off FSM. The hold-off counter sits at zero outside HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_take_c) begin
            state <= HOLD;
            hcnt  <= HCNT_LOAD;
          end
        end
        HOLD: begin
          if (hcnt == '0) begin
            state <= IDLE;
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          hcnt  <= '0;
        end
      endcase
    end
  end

  // Watchdog: consecutive stalled cycles. Any unstalled cycle, including HOLD and flush cycles, restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt            <= '0;
      stall_timeout_q <= 1'b0;
    end else if (stall_c != STALL_NONE) begin
      if (wcnt != '1) begin
        wcnt <= wcnt + WCNT_W'(1);
      end
      if (wcnt == WCNT_TRIP) begin
        stall_timeout_q <= 1'b1;
      end
    end else begin
      wcnt <= '0;
    end
  end

  // Saturating count of cycles in which the EX stage is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if (stall_c[3] && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CYC_W'(1);
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.stall_timeout = stall_timeout_q;

endmodule
